lane_rr_dispatcher: RTL and testbench

- Buffered round-robin dispatcher at the fan-out point of a five-child leaf group.
- Accepts one valid/ready input stream into a small FIFO.
- Delivers words to child lanes 0..LANES-1 in strict rotating order, one word per lane visit.
- Sits directly upstream of the leaf instances and feeds each of them through its own lane handshake.

---
 rtl/lane_rr_dispatcher_if.sv | 45 ++++
 rtl/lane_rr_dispatcher.sv | 109 ++++++++++
 tb/tb_lane_rr_dispatcher.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/lane_rr_dispatcher_if.sv
// lane_rr_dispatcher_if: bundles the upstream valid/ready stream, the
// per-lane downstream handshake and the dispatcher status outputs.
// Optional per-lane delivery counters are carried when DISPATCH_CNT_EN is defined.
interface lane_rr_dispatcher_if #(
  parameter int DATA_W = 8,
  parameter int LANES  = 5,
  parameter int DEPTH  = 4
);
  logic                       in_valid;
  logic                       in_ready;
  logic [DATA_W-1:0]          in_data;
  logic [LANES-1:0]           out_valid;
  logic [LANES-1:0]           out_ready;
  logic [DATA_W-1:0]          out_data;
  logic [$clog2(LANES)-1:0]   lane_ptr;
  logic [$clog2(DEPTH):0]     fifo_count;
  logic                       busy;
`ifdef DISPATCH_CNT_EN
  logic [16*LANES-1:0]        lane_cnt;

  // Upstream source plus lane sinks drive this side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, lane_ptr, fifo_count, busy, lane_cnt
  );

  // The dispatcher itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, lane_ptr, fifo_count, busy, lane_cnt
  );
`else
  // Upstream source plus lane sinks drive this side
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, lane_ptr, fifo_count, busy
  );

  // The dispatcher itself
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, lane_ptr, fifo_count, busy
  );
`endif
endinterface

// File: rtl/lane_rr_dispatcher.sv
// lane_rr_dispatcher: buffers one valid/ready stream in a small circular FIFO
// and hands the head word to child lanes in strict rotating order, waiting
// on the current lane for as long as it takes.
// Optional feature macro: DISPATCH_CNT_EN adds a 16-bit wrapping delivery
// counter per lane on the lane_cnt port.
module lane_rr_dispatcher #(
  parameter int DATA_W = 8,
  parameter int LANES  = 5,
  parameter int DEPTH  = 4
) (
  input logic                clk,
  input logic                rst,
  lane_rr_dispatcher_if.slave bus
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int LANE_W = $clog2(LANES);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [LANE_W-1:0] lanePtr_q, lanePtr_d;
  logic              fifoEmpty;
  logic              fifoFull;
  logic              push;
  logic              pop;

  // Full blocks a push even when a pop happens in the same cycle, which keeps
  // in_ready free of any combinational path from out_ready.
  assign fifoEmpty = (count_q == '0);
  assign fifoFull  = (count_q == CNT_W'(DEPTH));
  assign push      = bus.in_valid && !fifoFull;
  assign pop       = !fifoEmpty && bus.out_ready[lanePtr_q];

  // Next-state for pointers, occupancy and the lane rotation
  always_comb begin
    rdPtr_d   = rdPtr_q;
    wrPtr_d   = wrPtr_q;
    count_d   = count_q;
    lanePtr_d = lanePtr_q;
    if (push) begin
      wrPtr_d = wrPtr_q + 1'b1;
    end
    if (pop) begin
      rdPtr_d   = rdPtr_q + 1'b1;
      lanePtr_d = (lanePtr_q == LANE_W'(LANES - 1)) ? '0 : lanePtr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control state; reset discards all buffered words at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdPtr_q   <= '0;
      wrPtr_q   <= '0;
      count_q   <= '0;
      lanePtr_q <= '0;
    end else begin
      rdPtr_q   <= rdPtr_d;
      wrPtr_q   <= wrPtr_d;
      count_q   <= count_d;
      lanePtr_q <= lanePtr_d;
    end
  end

  // Payload storage needs no reset since out_data is masked while empty
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wrPtr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready   = !fifoFull;
  assign bus.out_valid  = fifoEmpty ? '0 : (LANES'(1) << lanePtr_q);
  assign bus.out_data   = fifoEmpty ? '0 : mem_q[rdPtr_q];
  assign bus.lane_ptr   = lanePtr_q;
  assign bus.fifo_count = count_q;
  assign bus.busy       = !fifoEmpty;

`ifdef DISPATCH_CNT_EN
  logic [15:0] laneCnt_q [LANES];

  // Per-lane delivery counters, wrapping naturally at 16 bits
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LANES; k++) begin
        laneCnt_q[k] <= '0;
      end
    end else if (pop) begin
      laneCnt_q[lanePtr_q] <= laneCnt_q[lanePtr_q] + 16'd1;
    end
  end

  // Pack lane k's counter into bits [16k+15:16k]
  always_comb begin
    bus.lane_cnt = '0;
    for (int k = 0; k < LANES; k++) begin
      bus.lane_cnt[16*k +: 16] = laneCnt_q[k];
    end
  end
`endif

endmodule

// File: tb/tb_lane_rr_dispatcher.sv
// tb_lane_rr_dispatcher: directed and random stimulus against a queue-based
// reference of the dispatcher (words in arrival order, word i to lane i mod LANES).
module tb_lane_rr_dispatcher;

  localparam int DATA_W = 8;
  localparam int LANES  = 5;
  localparam int DEPTH  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic [DATA_W-1:0] modelQ[$];
  int                modelPtr = 0;
  int                modelCnt [LANES];

  lane_rr_dispatcher_if #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) bus ();

  lane_rr_dispatcher #(.DATA_W(DATA_W), .LANES(LANES), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelClear();
    modelQ.delete();
    modelPtr = 0;
    for (int k = 0; k < LANES; k++) modelCnt[k] = 0;
  endtask

  // Compare every DUT output against what the model predicts for this cycle
  task automatic checkOutput(input string tag);
    logic [LANES-1:0] expValid;
    logic [DATA_W-1:0] expData;
    expValid = '0;
    expData  = '0;
    if (modelQ.size() != 0) begin
      expValid[modelPtr] = 1'b1;
      expData = modelQ[0];
    end
    checkVal({tag, "_in_ready"},   128'(bus.in_ready),   128'(modelQ.size() != DEPTH));
    checkVal({tag, "_out_valid"},  128'(bus.out_valid),  128'(expValid));
    checkVal({tag, "_out_data"},   128'(bus.out_data),   128'(expData));
    checkVal({tag, "_lane_ptr"},   128'(bus.lane_ptr),   128'(modelPtr));
    checkVal({tag, "_fifo_count"}, 128'(bus.fifo_count), 128'(modelQ.size()));
    checkVal({tag, "_busy"},       128'(bus.busy),       128'(modelQ.size() != 0));
`ifdef DISPATCH_CNT_EN
    begin
      logic [16*LANES-1:0] expCnt;
      for (int k = 0; k < LANES; k++) expCnt[16*k +: 16] = 16'(modelCnt[k]);
      checkVal({tag, "_lane_cnt"}, 128'(bus.lane_cnt), 128'(expCnt));
    end
`endif
  endtask

  // One cycle: drive at the falling edge, check, advance the model, clock
  task automatic applyStimulus(input string tag, input logic v, input logic [DATA_W-1:0] d,
                               input logic [LANES-1:0] r, output logic accepted);
    logic doPush, doPop;
    bus.in_valid  = v;
    bus.in_data   = d;
    bus.out_ready = r;
    #1;
    checkOutput(tag);
    doPush = v && (modelQ.size() < DEPTH);
    doPop  = (modelQ.size() > 0) && r[modelPtr];
    if (doPop) begin
      void'(modelQ.pop_front());
      modelCnt[modelPtr] = (modelCnt[modelPtr] + 1) % 65536;
      modelPtr = (modelPtr + 1) % LANES;
    end
    if (doPush) modelQ.push_back(d);
    accepted = doPush;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    @(negedge clk);
    rst = 1'b0;
    modelClear();
    @(negedge clk);
  endtask

  initial begin
    logic acc;
    logic [DATA_W-1:0] word;
    logic [LANES-1:0] rdy;

    modelClear();
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state with idle input
    applyStimulus("reset", 1'b0, 8'h00, '0, acc);
    checkVal("reset_out_valid_const", 128'(bus.out_valid), 128'(0));
    checkVal("reset_in_ready_const",  128'(bus.in_ready),  128'(1));

    // Rotation: continuous stream with every lane ready
    for (int i = 0; i < 7; i++) applyStimulus("rot", 1'b1, 8'(8'h10 + i), '1, acc);
    for (int i = 0; i < 3; i++) applyStimulus("rot_drain", 1'b0, 8'h00, '1, acc);
    checkVal("rot_ptr_end",   128'(bus.lane_ptr),   128'(2));
    checkVal("rot_count_end", 128'(bus.fifo_count), 128'(0));

    // Full / backpressure
    doReset();
    word = 8'hA0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus("full_fill", 1'b1, word, '0, acc);
      if (acc) word = word + 8'd1;
    end
    checkVal("full_count",    128'(bus.fifo_count), 128'(4));
    checkVal("full_in_ready", 128'(bus.in_ready),   128'(0));
    checkVal("full_held",     128'(word),           128'(8'hA4));
    applyStimulus("full_pop", 1'b1, word, 5'b00001, acc);
    checkVal("full_no_push_on_pop", 128'(acc), 128'(0));
    checkVal("full_head_after_pop", 128'(bus.out_data), 128'(8'hA1));
    applyStimulus("full_accept", 1'b1, word, 5'b00000, acc);
    checkVal("full_a4_accepted", 128'(acc), 128'(1));
    checkVal("full_count_after", 128'(bus.fifo_count), 128'(4));
    for (int i = 0; i < 8; i++) applyStimulus("full_drain", 1'b0, 8'h00, '1, acc);

    // Strict order: other lanes' ready is ignored
    doReset();
    applyStimulus("strict_load", 1'b1, 8'h01, '0, acc);
    for (int i = 0; i < 10; i++) applyStimulus("strict_wait", 1'b0, 8'h00, 5'b11110, acc);
    checkVal("strict_count_held", 128'(bus.fifo_count), 128'(1));
    applyStimulus("strict_go", 1'b0, 8'h00, 5'b00001, acc);
    checkVal("strict_ptr_after", 128'(bus.lane_ptr), 128'(1));

    // Simultaneous push and pop at count 2
    doReset();
    applyStimulus("sim_load", 1'b1, 8'h31, '0, acc);
    applyStimulus("sim_load", 1'b1, 8'h32, '0, acc);
    applyStimulus("sim_both", 1'b1, 8'h33, 5'b00001, acc);
    checkVal("sim_count_kept", 128'(bus.fifo_count), 128'(2));
    checkVal("sim_head",       128'(bus.out_data),   128'(8'h32));
    for (int i = 0; i < 3; i++) applyStimulus("sim_drain", 1'b0, 8'h00, '1, acc);

    // Reset mid-stream with count 3 and lane_ptr 3
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus("mid_rot", 1'b1, 8'(8'h50 + i), '1, acc);
    applyStimulus("mid_rot", 1'b0, 8'h00, '1, acc);
    for (int i = 0; i < 3; i++) applyStimulus("mid_fill", 1'b1, 8'(8'h60 + i), '0, acc);
    checkVal("mid_count_pre", 128'(bus.fifo_count), 128'(3));
    checkVal("mid_ptr_pre",   128'(bus.lane_ptr),   128'(3));
    #2 rst = 1'b1;
    #1;
    checkVal("mid_in_ready",   128'(bus.in_ready),   128'(1));
    checkVal("mid_out_valid",  128'(bus.out_valid),  128'(0));
    checkVal("mid_out_data",   128'(bus.out_data),   128'(0));
    checkVal("mid_lane_ptr",   128'(bus.lane_ptr),   128'(0));
    checkVal("mid_fifo_count", 128'(bus.fifo_count), 128'(0));
    checkVal("mid_busy",       128'(bus.busy),       128'(0));
`ifdef DISPATCH_CNT_EN
    checkVal("mid_lane_cnt",   128'(bus.lane_cnt),   128'(0));
`endif
    modelClear();
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    applyStimulus("post_reset", 1'b0, 8'h00, '0, acc);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      rdy = LANES'($urandom);
      applyStimulus("rand", 1'($urandom_range(0, 1)), DATA_W'($urandom), rdy, acc);
    end
    for (int i = 0; i < 6; i++) applyStimulus("rand_drain", 1'b0, 8'h00, '1, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
